// File: rtl/prbs_checker.sv
// PRBS receive checker: seeds a local Fibonacci LFSR from the incoming stream,
// then predicts every valid bit and reports errors, lock and loss of sync.
module prbs_checker #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(32'h8020_0003),
    parameter int unsigned      WIN_LEN    = 64,
    parameter int unsigned      ERR_THRESH = 8,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             sync_lost
);

    localparam int unsigned SEED_W = $clog2(WIDTH + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);

    typedef enum logic {
        ST_SEED   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e             state_q,     state_d;
    logic [WIDTH-1:0]   sreg_q,      sreg_d;
    logic [SEED_W-1:0]  seed_cnt_q,  seed_cnt_d;
    logic [WIN_W-1:0]   win_cnt_q,   win_cnt_d;
    logic [WIN_W-1:0]   win_err_q,   win_err_d;
    logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic               locked_q,    locked_d;
    logic               bit_err_q,   bit_err_d;
    logic               sync_lost_q, sync_lost_d;

    logic [WIDTH-1:0]   seed_shift_c;
    logic               pred_c;
    logic               mismatch_c;
    logic               seed_done_c;
    logic               win_end_c;
    logic               thresh_hit_c;

    // Decode of the current valid bit against the local register.
    assign seed_shift_c = {sreg_q[WIDTH-2:0], din};
    assign pred_c       = ^(sreg_q & TAPS);
    assign mismatch_c   = din ^ pred_c;
    assign seed_done_c  = (seed_cnt_q == SEED_W'(WIDTH - 1)) && (seed_shift_c != '0);
    assign win_end_c    = (win_cnt_q == WIN_W'(WIN_LEN - 1));
    assign thresh_hit_c = mismatch_c && (win_err_q == WIN_W'(ERR_THRESH - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_SEED: begin
                if (din_valid && seed_done_c) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (din_valid && thresh_hit_c) begin
                    state_d = ST_SEED;
                end
            end
            default: state_d = ST_SEED;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        sreg_d      = sreg_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        bit_err_d   = 1'b0;
        sync_lost_d = 1'b0;
        locked_d    = (state_d == ST_LOCKED);

        if (din_valid) begin
            unique case (state_q)
                ST_SEED: begin
                    sreg_d = seed_shift_c;
                    // An all-zero register restarts seeding so zeros never lock.
                    if (seed_shift_c == '0) begin
                        seed_cnt_d = '0;
                    end else if (seed_done_c) begin
                        seed_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else begin
                        seed_cnt_d = seed_cnt_q + SEED_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so channel errors do not propagate.
                    sreg_d    = {sreg_q[WIDTH-2:0], pred_c};
                    bit_err_d = mismatch_c;
                    if (mismatch_c && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (thresh_hit_c) begin
                        sync_lost_d = 1'b1;
                        sreg_d      = '0;
                        seed_cnt_d  = '0;
                        win_cnt_d   = '0;
                        win_err_d   = '0;
                    end else if (win_end_c) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_q + WIN_W'(mismatch_c);
                    end
                end
                default: ;
            endcase
        end

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q      <= '0;
            seed_cnt_q  <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            seed_cnt_q  <= seed_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            sync_lost_q <= sync_lost_d;
        end
    end

    assign locked    = locked_q;
    assign bit_err   = bit_err_q;
    assign err_cnt   = err_cnt_q;
    assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: golden PRBS source with directed and random bit
// errors and valid gaps, checked against a bit-history reference model.
module tb_prbs_checker;

    localparam int unsigned WIDTH      = 32;
    localparam logic [31:0] TAPS       = 32'h8020_0003;
    localparam int unsigned WIN_LEN    = 64;
    localparam int unsigned ERR_THRESH = 8;
    localparam int unsigned CNT_W      = 16;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_cnt;
    logic             sync_lost;

    prbs_checker #(
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .WIN_LEN    (WIN_LEN),
        .ERR_THRESH (ERR_THRESH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_cnt   (err_cnt),
        .sync_lost (sync_lost)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_berr = 0;
    int n_slost = 0;

    // Golden transmitter state.
    logic [31:0] g_state;

    // Reference model: history of the last WIDTH register bits, newest at back.
    bit m_hist[$];
    bit m_locked;
    int m_run;
    int m_wbits;
    int m_werrs;
    int m_err;
    bit e_bit_err;
    bit e_sync_lost;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        repeat (WIDTH) m_hist.push_back(1'b0);
        m_locked = 1'b0;
        m_run    = 0;
        m_wbits  = 0;
        m_werrs  = 0;
        m_err    = 0;
    endtask

    function automatic bit model_pred();
        bit p = 1'b0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            if (TAPS[k]) p ^= m_hist[m_hist.size() - 1 - k];
        end
        return p;
    endfunction

    function automatic int hist_ones();
        int n = 0;
        foreach (m_hist[i]) n += int'(m_hist[i]);
        return n;
    endfunction

    task automatic model_step(input bit v, input bit d, input bit c);
        bit p;
        e_bit_err   = 1'b0;
        e_sync_lost = 1'b0;
        if (v) begin
            if (!m_locked) begin
                m_hist.push_back(d);
                void'(m_hist.pop_front());
                if (hist_ones() == 0) begin
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == int'(WIDTH)) begin
                        m_locked = 1'b1;
                        m_run    = 0;
                        m_wbits  = 0;
                        m_werrs  = 0;
                    end
                end
            end else begin
                p = model_pred();
                m_hist.push_back(p);
                void'(m_hist.pop_front());
                e_bit_err = (d != p);
                if (e_bit_err) begin
                    if (m_err < CNT_MAX) m_err++;
                    m_werrs++;
                end
                m_wbits++;
                if (m_werrs == int'(ERR_THRESH)) begin
                    e_sync_lost = 1'b1;
                    m_locked    = 1'b0;
                    foreach (m_hist[i]) m_hist[i] = 1'b0;
                    m_run   = 0;
                    m_wbits = 0;
                    m_werrs = 0;
                end else if (m_wbits == int'(WIN_LEN)) begin
                    m_wbits = 0;
                    m_werrs = 0;
                end
            end
        end
        if (c) m_err = 0;
    endtask

    task automatic gen_bit(output bit b);
        b       = ^(g_state & TAPS);
        g_state = {g_state[30:0], b};
    endtask

    // One clock: drive, advance model, compare all outputs.
    task automatic step(input bit v, input bit d, input bit c);
        din_valid = v;
        din       = d;
        clr_cnt   = c;
        @(posedge clk);
        #1;
        model_step(v, d, c);
        chk("locked",    32'(locked),    32'(m_locked));
        chk("bit_err",   32'(bit_err),   32'(e_bit_err));
        chk("sync_lost", 32'(sync_lost), 32'(e_sync_lost));
        chk("err_cnt",   32'(err_cnt),   32'(m_err));
        if (bit_err)   n_berr++;
        if (sync_lost) n_slost++;
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        gen_bit(b);
        step(1'b1, b ^ flip, c);
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        rst       = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // Fresh seed, then check that lock rises exactly after the WIDTH-th bit.
    task automatic seed_and_check_lock(input string tag);
        g_state = 32'h0000_0001;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (i == int'(WIDTH) - 1) chk({tag, "_pre"}, 32'(locked), 32'd0);
            send(1'b0, 1'b0);
        end
        chk(tag, 32'(locked), 32'd1);
    endtask

    initial begin
        rst       = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked",    32'(locked),    32'd0);
        chk("rst_bit_err",   32'(bit_err),   32'd0);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_sync_lost", 32'(sync_lost), 32'd0);
        rst = 1'b1;

        // Clean stream of 10000 bits.
        n_berr = 0;
        seed_and_check_lock("lock_clean");
        for (int i = int'(WIDTH); i < 10000; i++) send(1'b0, 1'b0);
        chk("clean_no_bit_err", 32'(n_berr), 32'd0);
        chk("clean_err_cnt", 32'(err_cnt), 32'd0);

        // Single flipped bit.
        n_berr = 0;
        for (int i = 0; i < 200; i++) send(i == 100, 1'b0);
        chk("single_pulse_cnt", 32'(n_berr), 32'd1);
        chk("single_err_cnt", 32'(err_cnt), 32'd1);
        chk("single_locked", 32'(locked), 32'd1);

        // Eight errors inside one window force loss of sync.
        send(1'b0, 1'b1);
        for (int i = 0; i < int'(WIN_LEN) && m_wbits != 0; i++) send(1'b0, 1'b0);
        n_slost = 0;
        for (int i = 0; i < int'(ERR_THRESH); i++) send(1'b1, 1'b0);
        chk("loss_pulse_cnt", 32'(n_slost), 32'd1);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_err_cnt", 32'(err_cnt), 32'd8);
        for (int i = 0; i < 2 * int'(WIDTH) && !locked; i++) send(1'b0, 1'b0);
        chk("relock_after_loss", 32'(locked), 32'd1);
        for (int i = 0; i < 100; i++) send(1'b0, 1'b0);

        // All-zero input must never lock.
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
        chk("zeros_no_lock", 32'(locked), 32'd0);
        seed_and_check_lock("lock_after_zeros");

        // Random valid gaps on a clean stream.
        n_berr = 0;
        for (int i = 0; i < 2000; i++) begin
            if (($urandom % 2) == 1) send(1'b0, 1'b0);
            else step(1'b0, 1'($urandom % 2), 1'b0);
        end
        chk("gaps_no_bit_err", 32'(n_berr), 32'd0);
        chk("gaps_locked", 32'(locked), 32'd1);

        // Clear wins over a simultaneous error increment.
        send(1'b0, 1'b1);
        for (int e = 0; e < 5; e++) begin
            send(1'b1, 1'b0);
            for (int i = 0; i < 70; i++) send(1'b0, 1'b0);
        end
        chk("err_cnt_5", 32'(err_cnt), 32'd5);
        send(1'b1, 1'b1);
        chk("clr_vs_inc", 32'(err_cnt), 32'd0);
        chk("clr_vs_inc_pulse", 32'(bit_err), 32'd1);

        // Random errors, gaps and clears.
        for (int i = 0; i < 4000; i++) begin
            if (($urandom % 4) != 0) send(($urandom % 16) == 0, ($urandom % 200) == 0);
            else step(1'b0, 1'($urandom % 2), ($urandom % 200) == 0);
        end

        // Asynchronous reset while locked with three errors counted.
        do_reset();
        seed_and_check_lock("lock_pre_rst");
        for (int e = 0; e < 3; e++) begin
            send(1'b1, 1'b0);
            for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
        end
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'd3);
        chk("pre_rst_locked", 32'(locked), 32'd1);
        din_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_locked", 32'(locked), 32'd0);
        chk("async_rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        seed_and_check_lock("relock_after_rst");
        for (int i = 0; i < 50; i++) send(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
